// File: rtl/alu_result_stage_pkg.sv
// alu_result_stage_pkg: status-register bit positions, strobe indices, FSM states and hold-register layout
package alu_result_stage_pkg;
    localparam int P_N = 7;
    localparam int P_V = 6;
    localparam int P_U = 5;
    localparam int P_B = 4;
    localparam int P_D = 3;
    localparam int P_I = 2;
    localparam int P_Z = 1;
    localparam int P_C = 0;
    localparam int FS_SEC = 6;
    localparam int FS_SED = 5;
    localparam int FS_SEI = 4;
    localparam int FS_CLC = 3;
    localparam int FS_CLD = 2;
    localparam int FS_CLI = 1;
    localparam int FS_CLV = 0;
    localparam logic [7:0] P_RESET_DEFAULT = 8'h04;
    typedef enum logic [1:0] {IDLE, CAPTURE, ADJUST} state_t;
    typedef struct packed {
        logic [7:0] raw;
        logic       acr;
        logic       hc;
        logic       avr;
        logic       dec;
        logic       sub;
        logic       upd_nz;
        logic       upd_c;
        logic       upd_v;
        logic       bit_op;
        logic [1:0] db_nv;
    } hold_t;
    // B and the constant-1 bit are never stored, only driven onto p_out
    typedef struct packed {
        logic n;
        logic v;
        logic d;
        logic i;
        logic z;
        logic c;
    } flags_t;
endpackage

// File: rtl/alu_result_stage_if.sv
// alu_result_stage_if: ALU-side handshake, flag controls and result/status outputs of the result stage
interface alu_result_stage_if;
    logic       alu_valid;
    logic       alu_ready;
    logic [7:0] alu_out;
    logic       alu_acr;
    logic       alu_hc;
    logic       alu_avr;
    logic       dec_op;
    logic       sub_op;
    logic       upd_nz;
    logic       upd_c;
    logic       upd_v;
    logic       bit_op;
    logic [7:0] db_in;
    logic       p_load;
    logic [6:0] flag_set;
    logic       brk_flag;
    logic [7:0] result;
    logic       result_valid;
    logic [7:0] p_out;
    modport master (
        output alu_valid, alu_out, alu_acr, alu_hc, alu_avr, dec_op, sub_op,
        output upd_nz, upd_c, upd_v, bit_op, db_in, p_load, flag_set, brk_flag,
        input  alu_ready, result, result_valid, p_out
    );
    modport slave (
        input  alu_valid, alu_out, alu_acr, alu_hc, alu_avr, dec_op, sub_op,
        input  upd_nz, upd_c, upd_v, bit_op, db_in, p_load, flag_set, brk_flag,
        output alu_ready, result, result_valid, p_out
    );
endinterface

// File: rtl/alu_result_stage_decimal_corrector.sv
// decimal_corrector: NMOS-6502 BCD fixup of the raw ALU byte, driven by half carry and carry out
module decimal_corrector (
    input  logic [7:0] raw,
    input  logic       hc,
    input  logic       acr,
    input  logic       sub_op,
    output logic [7:0] result
);
    logic [7:0] adj;
    // ADC adds 6 where a digit carried; SBC subtracts 6 where a digit borrowed (carry absent)
    always_comb begin
        adj = {(acr ^ sub_op) ? 4'h6 : 4'h0, (hc ^ sub_op) ? 4'h6 : 4'h0};
        result = sub_op ? raw - adj : raw + adj;
    end
endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: registers ALU result/flags, applies decimal correction and maintains status register P
module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter logic [7:0] P_RESET = P_RESET_DEFAULT
) (
    input logic clk,
    input logic rst_n,
    alu_result_stage_if.slave bus
);
    state_t     state_q, state_d;
    hold_t      hold_q, hold_d;
    flags_t     flags_q, flags_d;
    logic [7:0] result_q, result_d;
    logic       result_valid_q, result_valid_d;
    logic [7:0] corrected;
    logic       nz_en, v_en, c_en, alu_n, alu_v;

    decimal_corrector u_dc (
        .raw    (hold_q.raw),
        .hc     (hold_q.hc),
        .acr    (hold_q.acr),
        .sub_op (hold_q.sub),
        .result (corrected)
    );

    always_comb begin
        state_d = state_q;
        hold_d = hold_q;
        result_d = result_q;
        result_valid_d = 1'b0;
        unique case (state_q)
            IDLE: if (bus.alu_valid) begin
                hold_d.raw = bus.alu_out;
                hold_d.acr = bus.alu_acr;
                hold_d.hc = bus.alu_hc;
                hold_d.avr = bus.alu_avr;
                hold_d.dec = bus.dec_op;
                hold_d.sub = bus.sub_op;
                hold_d.upd_nz = bus.upd_nz;
                hold_d.upd_c = bus.upd_c;
                hold_d.upd_v = bus.upd_v;
                hold_d.bit_op = bus.bit_op;
                hold_d.db_nv = bus.db_in[7:6];
                state_d = CAPTURE;
            end
            CAPTURE: begin
                state_d = hold_q.dec ? ADJUST : IDLE;
                result_d = hold_q.dec ? result_q : hold_q.raw;
                result_valid_d = ~hold_q.dec;
            end
            ADJUST: begin
                state_d = IDLE;
                result_d = corrected;
                result_valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // N/Z/V always come from the uncorrected byte; C lands with the final (possibly corrected) result
    always_comb begin
        nz_en = state_q == CAPTURE && (hold_q.upd_nz || hold_q.bit_op);
        v_en = state_q == CAPTURE && (hold_q.upd_v || hold_q.bit_op);
        c_en = hold_q.upd_c && (state_q == ADJUST || (state_q == CAPTURE && !hold_q.dec));
        alu_n = hold_q.bit_op ? hold_q.db_nv[1] : hold_q.raw[7];
        alu_v = hold_q.bit_op ? hold_q.db_nv[0] : hold_q.avr;
        flags_d.n = bus.p_load ? bus.db_in[P_N] : nz_en ? alu_n : flags_q.n;
        flags_d.v = bus.p_load ? bus.db_in[P_V] : bus.flag_set[FS_CLV] ? 1'b0 : v_en ? alu_v : flags_q.v;
        flags_d.d = bus.p_load ? bus.db_in[P_D] : bus.flag_set[FS_SED] ? 1'b1 : bus.flag_set[FS_CLD] ? 1'b0 : flags_q.d;
        flags_d.i = bus.p_load ? bus.db_in[P_I] : bus.flag_set[FS_SEI] ? 1'b1 : bus.flag_set[FS_CLI] ? 1'b0 : flags_q.i;
        flags_d.z = bus.p_load ? bus.db_in[P_Z] : nz_en ? hold_q.raw == 8'h00 : flags_q.z;
        flags_d.c = bus.p_load ? bus.db_in[P_C] : bus.flag_set[FS_SEC] ? 1'b1 : bus.flag_set[FS_CLC] ? 1'b0 : c_en ? hold_q.acr : flags_q.c;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q <= '0;
            result_q <= '0;
            result_valid_q <= 1'b0;
            flags_q <= {P_RESET[P_N], P_RESET[P_V], P_RESET[P_D], P_RESET[P_I], P_RESET[P_Z], P_RESET[P_C]};
        end else begin
            state_q <= state_d;
            hold_q <= hold_d;
            result_q <= result_d;
            result_valid_q <= result_valid_d;
            flags_q <= flags_d;
        end
    end

    assign bus.alu_ready = state_q == IDLE;
    assign bus.result = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.p_out = {flags_q.n, flags_q.v, 1'b1, bus.brk_flag, flags_q.d, flags_q.i, flags_q.z, flags_q.c};
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed and randomized checks of alu_result_stage against a transaction-level model
module tb_alu_result_stage;
    typedef struct packed {
        logic [7:0] raw;
        logic acr, hc, avr, dec, sub, nz, c, v, bt;
        logic [7:0] db;
    } op_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int passed = 0;
    int total = 0;
    logic [7:0] m_p;
    logic [7:0] m_res;

    always #5 clk = ~clk;

    alu_result_stage_if bus();
    alu_result_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    function automatic logic [7:0] exp_p();
        return {m_p[7:6], 1'b1, bus.brk_flag, m_p[3:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.alu_valid = 0; bus.alu_out = 0; bus.alu_acr = 0; bus.alu_hc = 0; bus.alu_avr = 0;
        bus.dec_op = 0; bus.sub_op = 0; bus.upd_nz = 0; bus.upd_c = 0; bus.upd_v = 0;
        bus.bit_op = 0; bus.db_in = 0; bus.p_load = 0; bus.flag_set = 0;
    endtask

    // clears first then sets so set wins; PLP applied last so it overrides everything
    task automatic strobe_model(input logic [6:0] fs, input logic pl, input logic [7:0] db);
        if (fs[3]) m_p[0] = 1'b0;
        if (fs[2]) m_p[3] = 1'b0;
        if (fs[1]) m_p[2] = 1'b0;
        if (fs[0]) m_p[6] = 1'b0;
        if (fs[6]) m_p[0] = 1'b1;
        if (fs[5]) m_p[3] = 1'b1;
        if (fs[4]) m_p[2] = 1'b1;
        if (pl) begin
            m_p[7:6] = db[7:6];
            m_p[3:0] = db[3:0];
        end
    endtask

    task automatic drive_op(input op_t op);
        bus.alu_out = op.raw; bus.alu_acr = op.acr; bus.alu_hc = op.hc; bus.alu_avr = op.avr;
        bus.dec_op = op.dec; bus.sub_op = op.sub; bus.upd_nz = op.nz; bus.upd_c = op.c;
        bus.upd_v = op.v; bus.bit_op = op.bt; bus.db_in = op.db;
    endtask

    task automatic run_op(input op_t op, input logic [6:0] fs1, input logic [6:0] fs2, input logic [6:0] fs3,
                          input logic pl2, input logic [7:0] pdb2, input logic noise, input string name);
        logic [7:0] er;
        int r;
        total++; if (bus.alu_ready !== 1'b1) $display("FAIL %s ready_before got=%b exp=1", name, bus.alu_ready); else passed++;
        drive_op(op);
        bus.alu_valid = 1'b1;
        bus.flag_set = fs1;
        tick();
        strobe_model(fs1, 1'b0, op.db);
        bus.alu_valid = noise; bus.alu_out = ~op.raw; bus.dec_op = ~op.dec;
        bus.flag_set = fs2; bus.p_load = pl2; bus.db_in = pdb2;
        total++; if (bus.alu_ready !== 1'b0) $display("FAIL %s ready_busy1 got=%b exp=0", name, bus.alu_ready); else passed++;
        total++; if (bus.result_valid !== 1'b0) $display("FAIL %s early_valid got=%b exp=0", name, bus.result_valid); else passed++;
        tick();
        if (op.nz || op.bt) begin
            m_p[7] = op.bt ? op.db[7] : op.raw[7];
            m_p[1] = op.raw == 8'h00;
        end
        if (op.v || op.bt) m_p[6] = op.bt ? op.db[6] : op.avr;
        if (!op.dec && op.c) m_p[0] = op.acr;
        strobe_model(fs2, pl2, pdb2);
        r = !op.dec ? int'(op.raw) : op.sub ? int'(op.raw) - (op.hc ? 0 : 6) - (op.acr ? 0 : 96)
                                            : int'(op.raw) + (op.hc ? 6 : 0) + (op.acr ? 96 : 0);
        er = r[7:0];
        if (op.dec) begin
            total++; if (bus.result_valid !== 1'b0) $display("FAIL %s dec_mid_valid got=%b exp=0", name, bus.result_valid); else passed++;
            total++; if (bus.alu_ready !== 1'b0) $display("FAIL %s ready_busy2 got=%b exp=0", name, bus.alu_ready); else passed++;
            total++; if (bus.result !== m_res) $display("FAIL %s dec_mid_result got=%h exp=%h", name, bus.result, m_res); else passed++;
            total++; if (bus.p_out !== exp_p()) $display("FAIL %s dec_mid_p got=%h exp=%h", name, bus.p_out, exp_p()); else passed++;
            bus.flag_set = fs3;
            bus.p_load = 1'b0;
            tick();
            if (op.c) m_p[0] = op.acr;
            strobe_model(fs3, 1'b0, 8'h00);
        end
        total++; if (bus.result_valid !== 1'b1) $display("FAIL %s valid got=%b exp=1", name, bus.result_valid); else passed++;
        total++; if (bus.result !== er) $display("FAIL %s result got=%h exp=%h", name, bus.result, er); else passed++;
        total++; if (bus.p_out !== exp_p()) $display("FAIL %s p_out got=%h exp=%h", name, bus.p_out, exp_p()); else passed++;
        total++; if (bus.alu_ready !== 1'b1) $display("FAIL %s ready_after got=%b exp=1", name, bus.alu_ready); else passed++;
        m_res = er;
        clear_inputs();
        tick();
        total++; if (bus.result_valid !== 1'b0) $display("FAIL %s pulse_len got=%b exp=0", name, bus.result_valid); else passed++;
        total++; if (bus.result !== m_res) $display("FAIL %s result_hold got=%h exp=%h", name, bus.result, m_res); else passed++;
        total++; if (bus.p_out !== exp_p()) $display("FAIL %s p_hold got=%h exp=%h", name, bus.p_out, exp_p()); else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        m_p = 8'h04;
        m_res = 8'h00;
        total++; if (bus.alu_ready !== 1'b1) $display("FAIL reset ready got=%b exp=1", bus.alu_ready); else passed++;
        total++; if (bus.result !== 8'h00) $display("FAIL reset result got=%h exp=00", bus.result); else passed++;
        total++; if (bus.result_valid !== 1'b0) $display("FAIL reset valid got=%b exp=0", bus.result_valid); else passed++;
        total++; if (bus.p_out !== 8'h24) $display("FAIL reset p_out got=%h exp=24", bus.p_out); else passed++;
        rst_n = 1'b1;
        bus.brk_flag = 1'b1;
        #1;
        total++; if (bus.p_out !== 8'h34) $display("FAIL brk_flag p_out got=%h exp=34", bus.p_out); else passed++;
        bus.brk_flag = 1'b0;
        tick();
    endtask

    task automatic test_adc_bin();
        op_t op = '{raw: 8'h80, acr: 0, hc: 0, avr: 1, dec: 0, sub: 0, nz: 1, c: 1, v: 1, bt: 0, db: 8'h00};
        run_op(op, 7'h00, 7'h00, 7'h00, 1'b0, 8'h00, 1'b0, "adc_bin");
        total++; if (bus.result !== 8'h80) $display("FAIL adc_bin const_result got=%h exp=80", bus.result); else passed++;
        total++; if (bus.p_out !== 8'hE4) $display("FAIL adc_bin const_p got=%h exp=E4", bus.p_out); else passed++;
    endtask

    task automatic test_adc_dec();
        op_t op = '{raw: 8'h7D, acr: 0, hc: 1, avr: 0, dec: 1, sub: 0, nz: 1, c: 1, v: 1, bt: 0, db: 8'h00};
        run_op(op, 7'h00, 7'h00, 7'h00, 1'b0, 8'h00, 1'b0, "adc_dec");
        total++; if (bus.result !== 8'h83) $display("FAIL adc_dec const_result got=%h exp=83", bus.result); else passed++;
        total++; if (bus.p_out[1:0] !== 2'b00) $display("FAIL adc_dec const_zc got=%b exp=00", bus.p_out[1:0]); else passed++;
    endtask

    task automatic test_sbc_dec();
        op_t op = '{raw: 8'hF1, acr: 0, hc: 1, avr: 0, dec: 1, sub: 1, nz: 1, c: 1, v: 1, bt: 0, db: 8'h00};
        run_op(op, 7'h00, 7'h00, 7'h00, 1'b0, 8'h00, 1'b1, "sbc_dec");
        total++; if (bus.result !== 8'h91) $display("FAIL sbc_dec const_result got=%h exp=91", bus.result); else passed++;
        total++; if (bus.p_out[0] !== 1'b0) $display("FAIL sbc_dec const_c got=%b exp=0", bus.p_out[0]); else passed++;
    endtask

    task automatic test_plp();
        bus.db_in = 8'hCF;
        bus.p_load = 1'b1;
        bus.flag_set = 7'b000_1000;
        tick();
        strobe_model(7'b000_1000, 1'b1, 8'hCF);
        clear_inputs();
        total++; if (bus.p_out !== 8'hEF) $display("FAIL plp const_p got=%h exp=EF", bus.p_out); else passed++;
        total++; if (bus.p_out !== exp_p()) $display("FAIL plp model_p got=%h exp=%h", bus.p_out, exp_p()); else passed++;
    endtask

    task automatic test_bit();
        op_t pre = '{raw: 8'h01, acr: 0, hc: 0, avr: 0, dec: 0, sub: 0, nz: 1, c: 0, v: 1, bt: 0, db: 8'h00};
        op_t op = '{raw: 8'h00, acr: 0, hc: 0, avr: 0, dec: 0, sub: 0, nz: 1, c: 0, v: 0, bt: 1, db: 8'hC0};
        run_op(pre, 7'h00, 7'h00, 7'h00, 1'b0, 8'h00, 1'b0, "bit_pre");
        run_op(op, 7'h00, 7'h00, 7'h00, 1'b0, 8'h00, 1'b0, "bit");
        total++; if ((bus.p_out & 8'hC2) !== 8'hC2) $display("FAIL bit const_nvz got=%h exp=C2", bus.p_out & 8'hC2); else passed++;
        bus.flag_set = 7'b000_0010;
        tick();
        strobe_model(7'b000_0010, 1'b0, 8'h00);
        bus.flag_set = 7'b001_0010;
        tick();
        strobe_model(7'b001_0010, 1'b0, 8'h00);
        clear_inputs();
        total++; if (bus.p_out[2] !== 1'b1) $display("FAIL sei_cli i got=%b exp=1", bus.p_out[2]); else passed++;
        total++; if (bus.p_out !== exp_p()) $display("FAIL sei_cli p got=%h exp=%h", bus.p_out, exp_p()); else passed++;
    endtask

    task automatic test_random();
        op_t op;
        logic [6:0] fs1, fs2, fs3;
        logic pl2;
        for (int k = 0; k < 40; k++) begin
            op.raw = 8'($urandom);
            op.acr = 1'($urandom_range(0, 1)); op.hc = 1'($urandom_range(0, 1)); op.avr = 1'($urandom_range(0, 1));
            op.dec = 1'($urandom_range(0, 1)); op.sub = 1'($urandom_range(0, 1)); op.nz = 1'($urandom_range(0, 1));
            op.c = 1'($urandom_range(0, 1)); op.v = 1'($urandom_range(0, 1)); op.bt = ($urandom_range(0, 4) == 0);
            op.db = 8'($urandom);
            fs1 = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h00;
            fs2 = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h00;
            fs3 = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h00;
            pl2 = ($urandom_range(0, 9) == 0);
            bus.brk_flag = 1'($urandom_range(0, 1));
            run_op(op, fs1, fs2, fs3, pl2, 8'($urandom), 1'($urandom_range(0, 1)), "rand");
        end
        bus.brk_flag = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        op_t op = '{raw: 8'h7D, acr: 0, hc: 1, avr: 0, dec: 1, sub: 0, nz: 1, c: 1, v: 1, bt: 0, db: 8'h00};
        drive_op(op);
        bus.alu_valid = 1'b1;
        tick();
        clear_inputs();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_p = 8'h04;
        m_res = 8'h00;
        total++; if (bus.result_valid !== 1'b0) $display("FAIL rst_mid valid got=%b exp=0", bus.result_valid); else passed++;
        total++; if (bus.result !== 8'h00) $display("FAIL rst_mid result got=%h exp=00", bus.result); else passed++;
        total++; if (bus.p_out !== 8'h24) $display("FAIL rst_mid p_out got=%h exp=24", bus.p_out); else passed++;
        total++; if (bus.alu_ready !== 1'b1) $display("FAIL rst_mid ready got=%b exp=1", bus.alu_ready); else passed++;
        tick();
        total++; if (bus.result_valid !== 1'b0) $display("FAIL rst_mid late_valid got=%b exp=0", bus.result_valid); else passed++;
    endtask

    initial begin
        clear_inputs();
        bus.brk_flag = 1'b0;
        test_reset();
        test_adc_bin();
        test_adc_dec();
        test_sbc_dec();
        test_plp();
        test_bit();
        test_random();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
